// File: rtl/mem_word_reader.sv
// Reads one word from a serial drum memory: waits for the requested word time on the
// requested line, shifts the word in LSB first, then reports it with a four-phase handshake.
module mem_word_reader #(
  parameter int unsigned WORD_BITS   = 29,
  parameter int unsigned LONG_WORDS  = 108,
  parameter int unsigned SHORT_WORDS = 4
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 BIT_EN,
  input  logic                 T0,
  input  logic [6:0]           WORD_TIME,
  input  logic [23:0]          LINE_BITS,
  input  logic                 REQ,
  input  logic [4:0]           REQ_LINE,
  input  logic [6:0]           REQ_WORD,
  output logic                 ACK,
  output logic                 ERR,
  output logic [WORD_BITS-1:0] RD_DATA,
  output logic                 BUSY
);

  localparam int unsigned     CntW    = $clog2(WORD_BITS + 1);
  localparam logic [6:0]      LongW   = 7'(LONG_WORDS);
  localparam logic [6:0]      ShortW  = 7'(SHORT_WORDS);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_BITS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [4:0]           r_line, w_line_next;
  logic [6:0]           r_word, w_word_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [WORD_BITS-1:0] r_data, w_data_next;
  logic                 r_ack, w_ack_next;
  logic                 r_err, w_err_next;
  logic                 r_busy;
  logic                 w_req_bad, w_short, w_match, w_bit;

  assign w_req_bad = (REQ_LINE > 5'd23) ||
                     ((REQ_LINE < 5'd20) ? (REQ_WORD >= LongW) : (REQ_WORD >= ShortW));
  assign w_short   = (r_line >= 5'd20);
  // Short lines repeat every four word times, so only the low bits select the word.
  assign w_match   = (WORD_TIME < LongW) &&
                     (w_short ? (WORD_TIME[1:0] == r_word[1:0]) : (WORD_TIME == r_word));
  assign w_bit     = LINE_BITS[r_line];

  always_comb begin
    w_state_next = r_state;
    w_line_next  = r_line;
    w_word_next  = r_word;
    w_cnt_next   = r_cnt;
    w_data_next  = r_data;
    w_ack_next   = r_ack;
    w_err_next   = r_err;
    unique case (r_state)
      StIdle: begin
        if (REQ) begin
          w_line_next = REQ_LINE;
          w_word_next = REQ_WORD;
          if (w_req_bad) begin
            w_state_next = StDone;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (!REQ) begin
          w_state_next = StIdle;
        end else if (BIT_EN && T0 && w_match) begin
          w_state_next   = StShift;
          w_data_next[0] = w_bit;
          w_cnt_next     = CntW'(1);
        end
      end
      StShift: begin
        if (!REQ) begin
          w_state_next = StIdle;
        end else if (BIT_EN) begin
          w_data_next[r_cnt] = w_bit;
          w_cnt_next         = r_cnt + CntW'(1);
          if (r_cnt == LastBit) begin
            w_state_next = StDone;
            w_ack_next   = 1'b1;
          end
        end
      end
      StDone: begin
        if (!REQ) begin
          w_state_next = StIdle;
          w_ack_next   = 1'b0;
          w_err_next   = 1'b0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_line  <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_line  <= w_line_next;
      r_word  <= w_word_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_ack   <= w_ack_next;
      r_err   <= w_err_next;
      r_busy  <= (w_state_next == StWait) || (w_state_next == StShift);
    end
  end

  assign ACK     = r_ack;
  assign ERR     = r_err;
  assign RD_DATA = r_data;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_mem_word_reader.sv
// Bench for mem_word_reader: a drum model drives the serial lines, requests push expected
// results into a scoreboard, and a monitor checks each ACK/ERR as it appears.
module tb_mem_word_reader;

  logic        CLOCK = 1'b0;
  logic        rst, BIT_EN, T0, REQ, ACK, ERR, BUSY;
  logic [6:0]  WORD_TIME, REQ_WORD;
  logic [23:0] LINE_BITS;
  logic [4:0]  REQ_LINE;
  logic [28:0] RD_DATA;

  always #5 CLOCK = ~CLOCK;

  mem_word_reader dut (
    .CLOCK(CLOCK), .rst(rst), .BIT_EN(BIT_EN), .T0(T0), .WORD_TIME(WORD_TIME),
    .LINE_BITS(LINE_BITS), .REQ(REQ), .REQ_LINE(REQ_LINE), .REQ_WORD(REQ_WORD),
    .ACK(ACK), .ERR(ERR), .RD_DATA(RD_DATA), .BUSY(BUSY)
  );

  typedef struct packed {
    logic        err;
    logic [28:0] data;
    logic [6:0]  end_wt;
  } exp_t;

  logic [28:0] mem_long [20][108];
  logic [28:0] mem_short [4][4];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cur_wt = 0;
  int          cur_bit = 0;
  bit          gap_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Drum model: one bit per BIT_EN, 29 bits per word time, 108 word times per revolution.
  initial begin
    int wt, b, gap;
    logic [23:0] lb;
    logic [28:0] w;
    wt = 0; b = 0; gap = 0;
    BIT_EN = 1'b0; T0 = 1'b0; WORD_TIME = '0; LINE_BITS = '0;
    forever begin
      @(negedge CLOCK);
      if (gap_mode && gap > 0) begin
        gap--;
        BIT_EN = 1'b0; T0 = 1'b0;
        WORD_TIME = 7'($urandom_range(0, 127));
        LINE_BITS = 24'($urandom);
      end else begin
        if (gap_mode) gap = 2 + (($urandom_range(0, 3) == 0) ? 1 : 0);
        for (int l = 0; l < 24; l++) begin
          if (l < 20) w = mem_long[l][wt];
          else        w = mem_short[l-20][wt%4];
          lb[l] = w[b];
        end
        BIT_EN = 1'b1; T0 = (b == 0); WORD_TIME = 7'(wt); LINE_BITS = lb;
        cur_wt = wt; cur_bit = b;
        b++;
        if (b == 29) begin
          b = 0;
          wt = (wt + 1) % 108;
        end
      end
    end
  end

  // Monitor: every new ACK/ERR must match the oldest outstanding expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge CLOCK); #1;
      if ((ACK || ERR) && !prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: actual ack=%b err=%b required no response", ACK, ERR);
        end else begin
          e = sb.pop_front();
          chk("err_flag", 32'(ERR), 32'(e.err));
          chk("ack_flag", 32'(ACK), 32'(!e.err));
          chk("rd_data", 32'(RD_DATA), 32'(e.data));
          if (!e.err) begin
            chk("ack_after_bit28", {23'd0, BIT_EN, 8'(cur_bit)}, {23'd0, 1'b1, 8'd28});
            chk("end_word_time", 32'(cur_wt), 32'(e.end_wt));
          end
        end
      end
      prev = ACK || ERR;
    end
  end

  task automatic wait_pos(input int wt, input int b);
    int n;
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < 40000) begin
      @(posedge CLOCK);
      n++;
      hit = BIT_EN && (cur_wt == wt) && (cur_bit == b);
    end
    if (!hit) chk("wait_pos_timeout", 32'(hit), 32'd1);
  endtask

  task automatic do_read(input logic [4:0] line, input logic [6:0] word, input exp_t e,
                         input string tag);
    int  cyc, busy_bad;
    bit  done;
    sb.push_back(e);
    @(negedge CLOCK);
    REQ = 1'b1; REQ_LINE = line; REQ_WORD = word;
    cyc = 0; busy_bad = 0; done = 1'b0;
    while (!done && cyc < 40000) begin
      @(posedge CLOCK); #1;
      cyc++;
      if (ACK || ERR) done = 1'b1;
      else if (!BUSY) busy_bad++;
      if (cyc == 1) begin
        REQ_LINE = 5'($urandom);
        REQ_WORD = 7'($urandom);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (e.err) begin
      chk({tag, "_err_latency"}, 32'(cyc), 32'd1);
    end else begin
      chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busy_at_ack"}, 32'(BUSY), 32'd0);
    end
    @(posedge CLOCK); #1;
    chk({tag, "_hold"}, 32'({ACK, ERR, RD_DATA}), 32'({!e.err, e.err, e.data}));
    @(negedge CLOCK);
    REQ = 1'b0;
    @(posedge CLOCK); #1;
    chk({tag, "_clear"}, 32'({ACK, ERR}), 32'd0);
  endtask

  initial begin
    int bad;
    #3000000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int l = 0; l < 20; l++)
      for (int w = 0; w < 108; w++)
        mem_long[l][w] = 29'((l * 32'h9E3779B9) ^ (w * 32'h2545F491) ^ 32'h0123_4567);
    for (int l = 0; l < 4; l++)
      for (int w = 0; w < 4; w++)
        mem_short[l][w] = 29'((l * 32'h0F1E_2D3C) ^ (w * 32'h5A5A_A5A5) ^ 32'h0765_4321);
    mem_long[5][37] = 29'h0ABCDEF;
    mem_short[2][2] = 29'h15555555;

    rst = 1'b1; REQ = 1'b0; REQ_LINE = '0; REQ_WORD = '0;
    repeat (3) @(negedge CLOCK);
    #1;
    chk("reset_ack", 32'(ACK), 32'd0);
    chk("reset_err", 32'(ERR), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_data", 32'(RD_DATA), 32'd0);
    @(negedge CLOCK);
    rst = 1'b0;

    do_read(5'd5, 7'd37, '{err: 1'b0, data: 29'h0ABCDEF, end_wt: 7'd37}, "long");

    wait_pos(9, 0);
    do_read(5'd22, 7'd2, '{err: 1'b0, data: 29'h15555555, end_wt: 7'd10}, "short");

    do_read(5'd24, 7'd0, '{err: 1'b1, data: 29'h15555555, end_wt: 7'd0}, "bad_line");
    do_read(5'd20, 7'd4, '{err: 1'b1, data: 29'h15555555, end_wt: 7'd0}, "bad_short_word");
    do_read(5'd3, 7'd108, '{err: 1'b1, data: 29'h15555555, end_wt: 7'd0}, "bad_long_word");

    wait_pos(1, 0);
    do_read(5'd0, 7'd0, '{err: 1'b0, data: mem_long[0][0], end_wt: 7'd0}, "wrap");

    // Abort: drop REQ while bit 10 of the word is on the lines.
    @(negedge CLOCK);
    REQ = 1'b1; REQ_LINE = 5'd0; REQ_WORD = 7'd0;
    wait_pos(0, 9);
    chk("abort_busy_in_shift", 32'(BUSY), 32'd1);
    @(negedge CLOCK);
    REQ = 1'b0;
    @(posedge CLOCK); #1;
    chk("abort_idle", 32'(BUSY), 32'd0);
    bad = 0;
    repeat (60) begin
      @(posedge CLOCK); #1;
      if (ACK || ERR) bad++;
    end
    chk("abort_no_ack", 32'(bad), 32'd0);
    chk("abort_data", 32'(RD_DATA), 32'(mem_long[0][0]));

    // Reset while bit 15 is being shifted.
    @(negedge CLOCK);
    REQ = 1'b1; REQ_LINE = 5'd5; REQ_WORD = 7'd37;
    wait_pos(37, 14);
    chk("rst_busy_in_shift", 32'(BUSY), 32'd1);
    @(negedge CLOCK);
    rst = 1'b1;
    #1;
    chk("rst_async_ack", 32'(ACK), 32'd0);
    chk("rst_async_err", 32'(ERR), 32'd0);
    chk("rst_async_busy", 32'(BUSY), 32'd0);
    chk("rst_async_data", 32'(RD_DATA), 32'd0);
    REQ = 1'b0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge CLOCK); #1;
      if (ACK || ERR || BUSY) bad++;
    end
    chk("rst_no_ack", 32'(bad), 32'd0);
    do_read(5'd19, 7'd107, '{err: 1'b0, data: mem_long[19][107], end_wt: 7'd107}, "after_rst");

    gap_mode = 1'b1;
    do_read(5'd7, 7'd50, '{err: 1'b0, data: mem_long[7][50], end_wt: 7'd50}, "gap_a");
    do_read(5'd13, 7'd5, '{err: 1'b0, data: mem_long[13][5], end_wt: 7'd5}, "gap_b");

    repeat (5) @(posedge CLOCK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
